// File: rtl/jk_excitation_counter_pkg.sv
// Shared JK helpers: the excitation table (next-state -> J/K) and the
// characteristic equation (J/K -> next-state), one bit at a time.
package jk_excitation_counter_pkg;

  // Returns {j, k}; don't-care entries resolve to 0 so hold drives J=K=0.
  function automatic logic [1:0] jk_excite(input logic q, input logic n);
    return {~q & n, q & ~n};
  endfunction

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_excitation_counter_jk.sv
// Single-bit JK flip-flop with asynchronous active-high clear.
module jk_cell
  import jk_excitation_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= jk_next(j, k, q);
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_excitation_counter.sv
// Modulo-MOD up/down counter built from JK cells: the desired next state is
// computed first and then translated into per-bit J/K drive.
module jk_excitation_counter
  import jk_excitation_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             tc
);

  if (WIDTH < 1 || WIDTH > 16 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_params
    $error("jk_excitation_counter: illegal WIDTH/MOD combination");
  end

  // The modulus is a 32-bit int, so the max-value subtraction never overflows
  // even at full range (modulus equal to 2**WIDTH).
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] n;

  always_comb begin
    n = Q;
    if (load) begin
      n = (din > MAX_VAL) ? MAX_VAL : din;
    end else if (en) begin
      if (up) begin
        // Out-of-range states (Q > MAX_VAL) fall back to 0 as well.
        n = (Q >= MAX_VAL) ? '0 : Q + 1'b1;
      end else begin
        n = (Q == '0) ? MAX_VAL : Q - 1'b1;
      end
    end
  end

  always_comb begin
    J = '0;
    K = '0;
    if (rst) begin
      K = '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        {J[i], K[i]} = jk_excite(Q[i], n[i]);
      end
    end
  end

  assign tc = ~rst & ~load & en & ((up & (Q == MAX_VAL)) | (~up & (Q == '0)));

  for (genvar g = 0; g < WIDTH; g++) begin : g_cells
    jk_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .j     (J[g]),
      .k     (K[g]),
      .q     (Q[g]),
      .q_bar (Q_bar[g])
    );
  end

  // The toggle entry of the JK table must never be used.
  always @(posedge clk) begin
    if (!rst) assert ((J & K) == '0);
  end

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Directed bench for jk_excitation_counter: a BCD instance (4/10) and a
// full-range instance (3/8), each checked against hand-derived values.
module tb_jk_excitation_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic       en4 = 0, up4 = 0, load4 = 0;
  logic [3:0] din4 = '0, q4, qb4, j4, k4;
  logic       tc4;

  logic       en3 = 0, up3 = 0, load3 = 0;
  logic [2:0] din3 = '0, q3, qb3, j3, k3;
  logic       tc3;

  always #5 clk = ~clk;

  jk_excitation_counter #(.WIDTH(4), .MOD(10)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .up(up4), .load(load4), .din(din4),
    .Q(q4), .Q_bar(qb4), .J(j4), .K(k4), .tc(tc4)
  );

  jk_excitation_counter #(.WIDTH(3), .MOD(8)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .up(up3), .load(load3), .din(din3),
    .Q(q3), .Q_bar(qb3), .J(j3), .K(k3), .tc(tc3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input logic l, input logic e, input logic u, input logic [3:0] d);
    load4 = l; en4 = e; up4 = u; din4 = d;
    #1;
  endtask

  task automatic set3(input logic l, input logic e, input logic u, input logic [2:0] d);
    load3 = l; en3 = e; up3 = u; din3 = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set4(0, 1, 1, 4'd0);
    repeat (3) step();
    checks++;
    if (q4 !== 4'd3) begin errors++; $display("FAIL reset_precount: Q=%0d expected 3", q4); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q4 !== 4'd0 || qb4 !== 4'hF) begin
      errors++; $display("FAIL reset_async: Q=%h Q_bar=%h expected 0/F", q4, qb4);
    end
    checks++;
    if (j4 !== 4'h0 || k4 !== 4'hF || tc4 !== 1'b0) begin
      errors++; $display("FAIL reset_jk: J=%h K=%h tc=%b expected 0/F/0", j4, k4, tc4);
    end
    step();
    checks++;
    if (q4 !== 4'd0) begin errors++; $display("FAIL reset_hold_edge: Q=%0d expected 0", q4); end
    rst = 1'b0;
    step();
    checks++;
    if (q4 !== 4'd1) begin errors++; $display("FAIL reset_release: Q=%0d expected 1", q4); end
  endtask

  task automatic test_up_wrap();
    set4(1, 0, 0, 4'd0);
    step();
    set4(0, 1, 1, 4'd0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (q4 !== 4'(i) || tc4 !== (i == 9)) begin
        errors++; $display("FAIL up_wrap_seq: step %0d Q=%0d tc=%b expected %0d/%b", i, q4, tc4, i, i == 9);
      end
      if (i == 9) begin
        checks++;
        if (j4 !== 4'b0000 || k4 !== 4'b1001) begin
          errors++; $display("FAIL up_wrap_jk: J=%b K=%b expected 0000/1001", j4, k4);
        end
      end
      step();
    end
    checks++;
    if (q4 !== 4'd0) begin errors++; $display("FAIL up_wrap_end: Q=%0d expected 0", q4); end
  endtask

  task automatic test_down_wrap();
    set4(1, 0, 0, 4'd0);
    step();
    set4(0, 1, 0, 4'd0);
    checks++;
    if (tc4 !== 1'b1 || j4 !== 4'b1001 || k4 !== 4'b0000) begin
      errors++; $display("FAIL down_wrap_jk: tc=%b J=%b K=%b expected 1/1001/0000", tc4, j4, k4);
    end
    step();
    checks++;
    if (q4 !== 4'd9 || tc4 !== 1'b0) begin
      errors++; $display("FAIL down_wrap_q: Q=%0d tc=%b expected 9/0", q4, tc4);
    end
    step();
    checks++;
    if (q4 !== 4'd8) begin errors++; $display("FAIL down_step: Q=%0d expected 8", q4); end
  endtask

  task automatic test_load_clamp();
    set4(1, 0, 0, 4'd9);
    step();
    set4(1, 1, 1, 4'd13);
    checks++;
    if (tc4 !== 1'b0 || j4 !== 4'b0000 || k4 !== 4'b0000) begin
      errors++; $display("FAIL load_priority: tc=%b J=%b K=%b expected 0/0000/0000", tc4, j4, k4);
    end
    step();
    checks++;
    if (q4 !== 4'd9) begin errors++; $display("FAIL load_clamp: Q=%0d expected 9", q4); end
    set4(1, 0, 0, 4'd5);
    checks++;
    if (j4 !== 4'b0100 || k4 !== 4'b1000) begin
      errors++; $display("FAIL load_jk: J=%b K=%b expected 0100/1000", j4, k4);
    end
    step();
    checks++;
    if (q4 !== 4'd5 || qb4 !== 4'b1010) begin
      errors++; $display("FAIL load_value: Q=%0d Q_bar=%b expected 5/1010", q4, qb4);
    end
    set4(0, 0, 1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q4 !== 4'd5 || j4 !== 4'b0000 || k4 !== 4'b0000 || tc4 !== 1'b0) begin
        errors++; $display("FAIL hold: cycle %0d Q=%0d J=%b K=%b tc=%b expected 5/0000/0000/0", i, q4, j4, k4, tc4);
      end
      step();
    end
  endtask

  task automatic test_full_range();
    set3(1, 0, 0, 3'd7);
    step();
    set3(0, 1, 1, 3'd0);
    checks++;
    if (tc3 !== 1'b1 || j3 !== 3'b000 || k3 !== 3'b111) begin
      errors++; $display("FAIL full_up_jk: tc=%b J=%b K=%b expected 1/000/111", tc3, j3, k3);
    end
    step();
    checks++;
    if (q3 !== 3'd0) begin errors++; $display("FAIL full_up_wrap: Q=%0d expected 0", q3); end
    set3(0, 1, 0, 3'd0);
    checks++;
    if (tc3 !== 1'b1 || j3 !== 3'b111 || k3 !== 3'b000) begin
      errors++; $display("FAIL full_down_jk: tc=%b J=%b K=%b expected 1/111/000", tc3, j3, k3);
    end
    step();
    checks++;
    if (q3 !== 3'd7) begin errors++; $display("FAIL full_down_wrap: Q=%0d expected 7", q3); end
  endtask

  task automatic test_random3();
    int m = 7;
    int exp_n;
    logic l, e, u;
    logic [2:0] d;
    for (int c = 0; c < 1000; c++) begin
      l = ($urandom_range(0, 7) == 0);
      e = $urandom_range(0, 1);
      u = $urandom_range(0, 1);
      d = 3'($urandom_range(0, 7));
      set3(l, e, u, d);
      checks++;
      if ((j3 & k3) !== 3'b000 || tc3 !== (!l && e && (u ? m == 7 : m == 0))) begin
        errors++; $display("FAIL rand3_comb: cycle %0d J=%b K=%b tc=%b model=%0d", c, j3, k3, tc3, m);
      end
      if (l) exp_n = d;
      else if (e) exp_n = u ? (m + 1) % 8 : (m + 7) % 8;
      else exp_n = m;
      step();
      m = exp_n;
      checks++;
      if (q3 !== 3'(m) || qb3 !== ~3'(m)) begin
        errors++; $display("FAIL rand3_q: cycle %0d Q=%0d Q_bar=%b expected %0d", c, q3, qb3, m);
      end
    end
  endtask

  task automatic test_random4();
    int m = 5;
    int exp_n;
    logic l, e, u;
    logic [3:0] d;
    for (int c = 0; c < 400; c++) begin
      l = ($urandom_range(0, 5) == 0);
      e = $urandom_range(0, 1);
      u = $urandom_range(0, 1);
      d = 4'($urandom_range(0, 15));
      set4(l, e, u, d);
      checks++;
      if ((j4 & k4) !== 4'b0000 || tc4 !== (!l && e && (u ? m == 9 : m == 0))) begin
        errors++; $display("FAIL rand4_comb: cycle %0d J=%b K=%b tc=%b model=%0d", c, j4, k4, tc4, m);
      end
      if (l) exp_n = (d > 9) ? 9 : int'(d);
      else if (e) exp_n = u ? (m + 1) % 10 : (m + 9) % 10;
      else exp_n = m;
      step();
      m = exp_n;
      checks++;
      if (q4 !== 4'(m)) begin
        errors++; $display("FAIL rand4_q: cycle %0d Q=%0d expected %0d", c, q4, m);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_full_range();
    test_random3();
    test_random4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
